csr_excp_unit: RTL and testbench

Control/status register file and exception commit unit. Consumes the writeback stage's commit-side interface (exception/ertn flush, CSR write, TLB-exception info, LL/SC bit update) and turns it into architectural LA32 CSR state and a front-end redirect. Also owns the constant timer and the interrupt-pending logic that the decode stage samples.

---
 rtl/csr_excp_unit.sv | 265 ++++++++++++++++++++++++++
 tb/tb_csr_excp_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_excp_unit.sv
// ---------------------------------------------------------------------------
// csr_excp_unit
// LA32 control/status register file plus exception/ertn commit logic.
// Takes the writeback stage's commit-side strobes, updates architectural CSR
// state, produces the front-end redirect, runs the constant timer and
// computes the pending-interrupt flag sampled by decode.
//
// Ports
//   clk, reset            clock; asynchronous active-low reset
//   rd_addr / rd_data     combinational CSR read of registered state
//   csr_wr_en, wr_csr_*   CSR write port (ignored while a flush commits)
//   excp_flush, ertn_flush, csr_era, csr_ecode, csr_esubcode,
//   va_error, bad_va, excp_tlbrefill, excp_tlb, excp_tlb_vppn
//                         commit-side exception / ertn information
//   ws_llbit_set, ws_llbit  LL/SC bit update
//   hw_int_in, ipi_int_in external interrupt levels
//   has_int               enabled interrupt pending
//   redirect_valid/_pc    front-end redirect
//   crmd_plv/da/pg, llbit architectural mode outputs
// ---------------------------------------------------------------------------
module csr_excp_unit #(
    parameter int TIMER_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] rd_addr,
    output logic [31:0] rd_data,
    input  logic        csr_wr_en,
    input  logic [13:0] wr_csr_addr,
    input  logic [31:0] wr_csr_data,
    input  logic        excp_flush,
    input  logic        ertn_flush,
    input  logic [31:0] csr_era,
    input  logic [5:0]  csr_ecode,
    input  logic [8:0]  csr_esubcode,
    input  logic        va_error,
    input  logic [31:0] bad_va,
    input  logic        excp_tlbrefill,
    input  logic        excp_tlb,
    input  logic [18:0] excp_tlb_vppn,
    input  logic        ws_llbit_set,
    input  logic        ws_llbit,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    output logic        has_int,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic [1:0]  crmd_plv,
    output logic        crmd_da,
    output logic        crmd_pg,
    output logic        llbit
);

    localparam logic [13:0] A_CRMD   = 14'h000;
    localparam logic [13:0] A_PRMD   = 14'h001;
    localparam logic [13:0] A_ECFG   = 14'h004;
    localparam logic [13:0] A_ESTAT  = 14'h005;
    localparam logic [13:0] A_ERA    = 14'h006;
    localparam logic [13:0] A_BADV   = 14'h007;
    localparam logic [13:0] A_EENTRY = 14'h00C;
    localparam logic [13:0] A_TLBEHI = 14'h011;
    localparam logic [13:0] A_SAVE0  = 14'h030;
    localparam logic [13:0] A_TID    = 14'h040;
    localparam logic [13:0] A_TCFG   = 14'h041;
    localparam logic [13:0] A_TVAL   = 14'h042;
    localparam logic [13:0] A_TICLR  = 14'h044;
    localparam logic [13:0] A_LLBCTL = 14'h060;
    localparam logic [13:0] A_TLBREN = 14'h088;

    logic [8:0]         r_crmd;
    logic [2:0]         r_prmd;
    logic [12:0]        r_ecfg_lie;
    logic [1:0]         r_is_sw;
    logic [7:0]         r_is_hw;
    logic               r_is_ti;
    logic               r_is_ipi;
    logic [5:0]         r_ecode;
    logic [8:0]         r_esubcode;
    logic [31:0]        r_era;
    logic [31:0]        r_badv;
    logic [25:0]        r_eentry;
    logic [25:0]        r_tlbrentry;
    logic [18:0]        r_tlbehi_vppn;
    logic [31:0]        r_tid;
    logic               r_tcfg_en;
    logic               r_tcfg_per;
    logic [TIMER_W-3:0] r_tcfg_init;
    logic [TIMER_W-1:0] r_tval;
    logic               r_llbit;
    logic               r_klo;

    logic               w_flush;
    logic               w_ertn;
    logic               w_wr;
    logic               w_tcfg_wr;
    logic               w_ticlr;
    logic               w_fire;
    logic [12:0]        w_is;
    logic [31:0]        w_save [0:3];

    // Exception wins over ertn; any flush suppresses the write port.
    assign w_flush   = excp_flush | ertn_flush;
    assign w_ertn    = ertn_flush & ~excp_flush;
    assign w_wr      = csr_wr_en & ~w_flush;
    assign w_tcfg_wr = w_wr && (wr_csr_addr == A_TCFG);
    assign w_ticlr   = w_wr && (wr_csr_addr == A_TICLR) && wr_csr_data[0];
    // A TCFG write reloads the counter instead of letting it expire.
    assign w_fire    = ~w_tcfg_wr & r_tcfg_en & (r_tval == '0);

    assign w_is = {r_is_ipi, r_is_ti, 1'b0, r_is_hw, r_is_sw};

    // CRMD / PRMD: hardware commit updates take priority over writes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_crmd <= 9'h008;
            r_prmd <= 3'b000;
        end else if (excp_flush) begin
            r_prmd      <= r_crmd[2:0];
            r_crmd[2:0] <= 3'b000;
            if (excp_tlbrefill) begin
                r_crmd[3] <= 1'b1;
                r_crmd[4] <= 1'b0;
            end
        end else if (w_ertn) begin
            r_crmd[2:0] <= r_prmd;
            if (r_ecode == 6'h3F) begin
                r_crmd[3] <= 1'b0;
                r_crmd[4] <= 1'b1;
            end
        end else if (w_wr) begin
            if (wr_csr_addr == A_CRMD) r_crmd <= wr_csr_data[8:0];
            if (wr_csr_addr == A_PRMD) r_prmd <= wr_csr_data[2:0];
        end
    end

    // Exception bookkeeping registers and plain software registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ecfg_lie    <= '0;
            r_is_sw       <= '0;
            r_is_hw       <= '0;
            r_is_ipi      <= 1'b0;
            r_ecode       <= '0;
            r_esubcode    <= '0;
            r_era         <= '0;
            r_badv        <= '0;
            r_eentry      <= '0;
            r_tlbrentry   <= '0;
            r_tlbehi_vppn <= '0;
            r_tid         <= '0;
        end else begin
            r_is_hw  <= hw_int_in;
            r_is_ipi <= ipi_int_in;
            if (excp_flush) begin
                r_era      <= csr_era;
                r_ecode    <= csr_ecode;
                r_esubcode <= csr_esubcode;
                if (va_error) r_badv        <= bad_va;
                if (excp_tlb) r_tlbehi_vppn <= excp_tlb_vppn;
            end else if (w_wr) begin
                case (wr_csr_addr)
                    A_ECFG:   r_ecfg_lie    <= wr_csr_data[12:0] & 13'h1BFF;
                    A_ESTAT:  r_is_sw       <= wr_csr_data[1:0];
                    A_ERA:    r_era         <= wr_csr_data;
                    A_BADV:   r_badv        <= wr_csr_data;
                    A_EENTRY: r_eentry      <= wr_csr_data[31:6];
                    A_TLBREN: r_tlbrentry   <= wr_csr_data[31:6];
                    A_TLBEHI: r_tlbehi_vppn <= wr_csr_data[31:13];
                    A_TID:    r_tid         <= wr_csr_data;
                    default:  ;
                endcase
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_save
            logic [31:0] r_save;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_save <= '0;
                end else if (w_wr && (wr_csr_addr == A_SAVE0 + 14'(gi))) begin
                    r_save <= wr_csr_data;
                end
            end
            assign w_save[gi] = r_save;
        end
    endgenerate

    // Constant timer; expiry sets IS[11], which outranks a same-cycle TICLR.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tcfg_en   <= 1'b0;
            r_tcfg_per  <= 1'b0;
            r_tcfg_init <= '0;
            r_tval      <= '0;
            r_is_ti     <= 1'b0;
        end else begin
            if (w_tcfg_wr) begin
                r_tcfg_en   <= wr_csr_data[0];
                r_tcfg_per  <= wr_csr_data[1];
                r_tcfg_init <= wr_csr_data[TIMER_W-1:2];
                r_tval      <= {wr_csr_data[TIMER_W-1:2], 2'b00};
            end else if (r_tcfg_en) begin
                if (r_tval != '0)    r_tval    <= r_tval - TIMER_W'(1);
                else if (r_tcfg_per) r_tval    <= {r_tcfg_init, 2'b00};
                else                 r_tcfg_en <= 1'b0;
            end
            if (w_fire)       r_is_ti <= 1'b1;
            else if (w_ticlr) r_is_ti <= 1'b0;
        end
    end

    // LL bit: ertn clear, then writeback set, then WCLLB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_llbit <= 1'b0;
            r_klo   <= 1'b0;
        end else if (w_ertn) begin
            if (!r_klo) r_llbit <= 1'b0;
            r_klo <= 1'b0;
        end else if (!w_flush) begin
            if (ws_llbit_set)
                r_llbit <= ws_llbit;
            else if (w_wr && (wr_csr_addr == A_LLBCTL) && wr_csr_data[1])
                r_llbit <= 1'b0;
            if (w_wr && (wr_csr_addr == A_LLBCTL)) r_klo <= wr_csr_data[2];
        end
    end

    always_comb begin
        rd_data = '0;
        case (rd_addr)
            A_CRMD:          rd_data = {23'b0, r_crmd};
            A_PRMD:          rd_data = {29'b0, r_prmd};
            A_ECFG:          rd_data = {19'b0, r_ecfg_lie};
            A_ESTAT:         rd_data = {1'b0, r_esubcode, r_ecode, 3'b0, w_is};
            A_ERA:           rd_data = r_era;
            A_BADV:          rd_data = r_badv;
            A_EENTRY:        rd_data = {r_eentry, 6'b0};
            A_TLBREN:        rd_data = {r_tlbrentry, 6'b0};
            A_TLBEHI:        rd_data = {r_tlbehi_vppn, 13'b0};
            A_SAVE0:         rd_data = w_save[0];
            A_SAVE0 + 14'd1: rd_data = w_save[1];
            A_SAVE0 + 14'd2: rd_data = w_save[2];
            A_SAVE0 + 14'd3: rd_data = w_save[3];
            A_TID:           rd_data = r_tid;
            A_TCFG:          rd_data = 32'({r_tcfg_init, r_tcfg_per, r_tcfg_en});
            A_TVAL:          rd_data = 32'(r_tval);
            A_LLBCTL:        rd_data = {29'b0, r_klo, 1'b0, r_llbit};
            default:         rd_data = '0;
        endcase
    end

    assign has_int        = r_crmd[2] & (|(w_is & r_ecfg_lie));
    assign redirect_valid = w_flush;
    assign redirect_pc    = excp_flush ? (excp_tlbrefill ? {r_tlbrentry, 6'b0}
                                                         : {r_eentry, 6'b0})
                                       : r_era;
    assign crmd_plv       = r_crmd[1:0];
    assign crmd_da        = r_crmd[3];
    assign crmd_pg        = r_crmd[4];
    assign llbit          = r_llbit;

endmodule

// File: tb/tb_csr_excp_unit.sv
// ---------------------------------------------------------------------------
// tb_csr_excp_unit
// Directed-vector bench for csr_excp_unit. Inputs change 1 ns after the
// rising edge; outputs are sampled 1 ns after an input/address change.
// ---------------------------------------------------------------------------
module tb_csr_excp_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] rd_addr;
    logic [31:0] rd_data;
    logic        csr_wr_en;
    logic [13:0] wr_csr_addr;
    logic [31:0] wr_csr_data;
    logic        excp_flush;
    logic        ertn_flush;
    logic [31:0] csr_era;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic        va_error;
    logic [31:0] bad_va;
    logic        excp_tlbrefill;
    logic        excp_tlb;
    logic [18:0] excp_tlb_vppn;
    logic        ws_llbit_set;
    logic        ws_llbit;
    logic [7:0]  hw_int_in;
    logic        ipi_int_in;
    logic        has_int;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic [1:0]  crmd_plv;
    logic        crmd_da;
    logic        crmd_pg;
    logic        llbit;

    int n_checks = 0;
    int n_fail   = 0;

    csr_excp_unit #(.TIMER_W(32)) dut (
        .clk(clk), .reset(reset),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .csr_wr_en(csr_wr_en), .wr_csr_addr(wr_csr_addr), .wr_csr_data(wr_csr_data),
        .excp_flush(excp_flush), .ertn_flush(ertn_flush),
        .csr_era(csr_era), .csr_ecode(csr_ecode), .csr_esubcode(csr_esubcode),
        .va_error(va_error), .bad_va(bad_va),
        .excp_tlbrefill(excp_tlbrefill), .excp_tlb(excp_tlb), .excp_tlb_vppn(excp_tlb_vppn),
        .ws_llbit_set(ws_llbit_set), .ws_llbit(ws_llbit),
        .hw_int_in(hw_int_in), .ipi_int_in(ipi_int_in),
        .has_int(has_int), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .crmd_plv(crmd_plv), .crmd_da(crmd_da), .crmd_pg(crmd_pg), .llbit(llbit)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, obs);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        csr_wr_en   = 1'b1;
        wr_csr_addr = a;
        wr_csr_data = d;
        cyc();
        csr_wr_en   = 1'b0;
    endtask

    task automatic rd_chk(input string tag, input logic [13:0] a, input logic [31:0] exp);
        rd_addr = a;
        #1;
        check_val(tag, rd_data, exp);
    endtask

    task automatic clear_commit();
        excp_flush = 1'b0; ertn_flush = 1'b0; csr_era = '0; csr_ecode = '0;
        csr_esubcode = '0; va_error = 1'b0; bad_va = '0; excp_tlbrefill = 1'b0;
        excp_tlb = 1'b0; excp_tlb_vppn = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; rd_addr = '0; csr_wr_en = 1'b0; wr_csr_addr = '0; wr_csr_data = '0;
        ws_llbit_set = 1'b0; ws_llbit = 1'b0; hw_int_in = '0; ipi_int_in = 1'b0;
        clear_commit();
        repeat (3) cyc();
        reset = 1'b1;
        cyc();

        // Reset state
        rd_chk("rst_crmd",   14'h000, 32'h8);
        rd_chk("rst_prmd",   14'h001, 32'h0);
        rd_chk("rst_ecfg",   14'h004, 32'h0);
        rd_chk("rst_estat",  14'h005, 32'h0);
        rd_chk("rst_era",    14'h006, 32'h0);
        rd_chk("rst_eentry", 14'h00C, 32'h0);
        rd_chk("rst_tcfg",   14'h041, 32'h0);
        rd_chk("rst_tval",   14'h042, 32'h0);
        rd_chk("rst_llbctl", 14'h060, 32'h0);
        check_val("rst_has_int", has_int, 0);
        check_val("rst_llbit", llbit, 0);
        check_val("rst_da", crmd_da, 1);
        check_val("rst_redir_v", redirect_valid, 0);

        // Exception then ertn
        wr(14'h000, 32'h7);
        wr(14'h00C, 32'h1C00_0040);
        rd_chk("crmd_wr", 14'h000, 32'h7);
        excp_flush = 1'b1; csr_era = 32'h1C00_1000; csr_ecode = 6'h0B;
        #1;
        check_val("excp_redir_v", redirect_valid, 1);
        check_val("excp_redir_pc", redirect_pc, 32'h1C00_0040);
        cyc();
        clear_commit();
        rd_chk("excp_prmd",  14'h001, 32'h7);
        rd_chk("excp_crmd",  14'h000, 32'h0);
        rd_chk("excp_era",   14'h006, 32'h1C00_1000);
        rd_chk("excp_estat", 14'h005, 32'h000B_0000);
        ertn_flush = 1'b1;
        #1;
        check_val("ertn_redir_pc", redirect_pc, 32'h1C00_1000);
        cyc();
        clear_commit();
        rd_chk("ertn_crmd", 14'h000, 32'h7);

        // TLB refill exception then ertn with Ecode 0x3F
        wr(14'h088, 32'h0000_1000);
        excp_flush = 1'b1; excp_tlbrefill = 1'b1; excp_tlb = 1'b1; va_error = 1'b1;
        bad_va = 32'h8000_2000; excp_tlb_vppn = 19'h40001; csr_ecode = 6'h3F;
        csr_era = 32'h1C00_2000;
        #1;
        check_val("tlbr_redir_pc", redirect_pc, 32'h0000_1000);
        cyc();
        clear_commit();
        check_val("tlbr_da", crmd_da, 1);
        check_val("tlbr_pg", crmd_pg, 0);
        rd_chk("tlbr_crmd",   14'h000, 32'h8);
        rd_chk("tlbr_badv",   14'h007, 32'h8000_2000);
        rd_chk("tlbr_tlbehi", 14'h011, 32'h8000_2000);
        ertn_flush = 1'b1;
        #1;
        check_val("tlbr_ertn_pc", redirect_pc, 32'h1C00_2000);
        cyc();
        clear_commit();
        check_val("tlbr_ertn_da", crmd_da, 0);
        check_val("tlbr_ertn_pg", crmd_pg, 1);
        rd_chk("tlbr_ertn_crmd", 14'h000, 32'h17);

        // One-shot timer
        wr(14'h004, 32'h0000_1FFF);
        rd_chk("ecfg_mask", 14'h004, 32'h0000_1BFF);
        wr(14'h004, 32'h0000_0800);
        wr(14'h000, 32'h4);
        wr(14'h041, 32'h9);
        rd_chk("tval_load", 14'h042, 32'd8);
        check_val("tmr_int_0", has_int, 0);
        for (int i = 1; i <= 8; i++) begin
            cyc();
            rd_chk($sformatf("tval_%0d", i), 14'h042, 32'(8 - i));
            check_val($sformatf("tmr_int_%0d", i), has_int, 0);
        end
        cyc();
        check_val("tmr_fire_int", has_int, 1);
        rd_chk("tmr_fire_tcfg",  14'h041, 32'h8);
        rd_chk("tmr_fire_estat", 14'h005, 32'h003F_0800);
        cyc();
        check_val("tmr_hold_int", has_int, 1);
        rd_chk("tmr_hold_tval", 14'h042, 32'h0);
        wr(14'h044, 32'h1);
        check_val("ticlr_int", has_int, 0);
        rd_chk("ticlr_read", 14'h044, 32'h0);

        // Periodic timer with InitVal=0: fires every cycle, outranks TICLR
        wr(14'h041, 32'h3);
        check_val("per_int_0", has_int, 0);
        cyc();
        check_val("per_int_1", has_int, 1);
        rd_chk("per_tcfg", 14'h041, 32'h3);
        wr(14'h044, 32'h1);
        check_val("per_ticlr_lose", has_int, 1);
        wr(14'h041, 32'h0);
        wr(14'h044, 32'h1);
        check_val("per_ticlr_win", has_int, 0);

        // Hardware interrupt line, one register stage
        wr(14'h004, 32'h0000_0004);
        hw_int_in = 8'h01;
        #1;
        check_val("hwi_before", has_int, 0);
        cyc();
        check_val("hwi_after", has_int, 1);
        rd_chk("hwi_estat", 14'h005, 32'h003F_0004);
        hw_int_in = 8'h00;
        cyc();
        check_val("hwi_clear", has_int, 0);

        // LL bit
        ws_llbit_set = 1'b1; ws_llbit = 1'b1;
        cyc();
        ws_llbit_set = 1'b0;
        check_val("ll_set", llbit, 1);
        rd_chk("ll_llbctl", 14'h060, 32'h1);
        ertn_flush = 1'b1;
        cyc();
        clear_commit();
        check_val("ll_ertn_clr", llbit, 0);
        ws_llbit_set = 1'b1;
        cyc();
        ws_llbit_set = 1'b0;
        wr(14'h060, 32'h2);
        check_val("ll_wcllb", llbit, 0);
        rd_chk("ll_wcllb_rd", 14'h060, 32'h0);
        ws_llbit_set = 1'b1;
        cyc();
        ws_llbit_set = 1'b0;
        wr(14'h060, 32'h4);
        rd_chk("ll_klo_rd", 14'h060, 32'h5);
        ertn_flush = 1'b1;
        cyc();
        clear_commit();
        check_val("ll_klo_keep", llbit, 1);
        rd_chk("ll_klo_cleared", 14'h060, 32'h1);

        // Write suppressed by a same-cycle exception
        csr_wr_en = 1'b1; wr_csr_addr = 14'h030; wr_csr_data = 32'hDEAD_BEEF;
        excp_flush = 1'b1;
        cyc();
        csr_wr_en = 1'b0;
        clear_commit();
        rd_chk("save0_blocked", 14'h030, 32'h0);
        wr(14'h030, 32'hDEAD_BEEF);
        rd_chk("save0_wr", 14'h030, 32'hDEAD_BEEF);
        wr(14'h033, 32'h1234_5678);
        rd_chk("save3_wr", 14'h033, 32'h1234_5678);
        rd_chk("save1_zero", 14'h031, 32'h0);

        // Asynchronous reset mid-cycle
        #1;
        reset = 1'b0;
        rd_chk("arst_save0", 14'h030, 32'h0);
        rd_chk("arst_crmd", 14'h000, 32'h8);
        check_val("arst_llbit", llbit, 0);
        cyc();
        reset = 1'b1;
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
